// File: rtl/mccu_wait.sv
// Multicycle MIPS control unit with memory wait-state handshake,
// bounded-wait timeout and illegal-instruction trapping.
module mccu_wait #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int TO_W        = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic [3:0] aluc,
  output logic       shift,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic       jal,
  output logic       sext,
  output logic [2:0] state,
  output logic       illegal,
  output logic       mem_timeout,
  output logic       fault
);

  localparam logic [2:0] S_IF    = 3'd0;
  localparam logic [2:0] S_ID    = 3'd1;
  localparam logic [2:0] S_EXE   = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_ZERO = {TO_W{1'b0}};
  localparam logic [TO_W-1:0] CNT_ONE  = TO_W'(1);

  logic [2:0]      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            illegal_q, illegal_d;
  logic            timeout_q, timeout_d;

  // Instruction decode
  logic is_r;
  logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
  logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
  logic i_imm_alu, i_shift, legal;
  logic rdy, wait_hit;
  logic [3:0] alu_code;

  assign is_r   = (op == 6'b000000);
  assign i_add  = is_r & (func == 6'b100000);
  assign i_sub  = is_r & (func == 6'b100010);
  assign i_and  = is_r & (func == 6'b100100);
  assign i_or   = is_r & (func == 6'b100101);
  assign i_xor  = is_r & (func == 6'b100110);
  assign i_sll  = is_r & (func == 6'b000000);
  assign i_srl  = is_r & (func == 6'b000010);
  assign i_sra  = is_r & (func == 6'b000011);
  assign i_jr   = is_r & (func == 6'b001000);
  assign i_addi = (op == 6'b001000);
  assign i_andi = (op == 6'b001100);
  assign i_ori  = (op == 6'b001101);
  assign i_xori = (op == 6'b001110);
  assign i_lui  = (op == 6'b001111);
  assign i_lw   = (op == 6'b100011);
  assign i_sw   = (op == 6'b101011);
  assign i_beq  = (op == 6'b000100);
  assign i_bne  = (op == 6'b000101);
  assign i_j    = (op == 6'b000010);
  assign i_jal  = (op == 6'b000011);

  assign i_imm_alu = i_addi | i_andi | i_ori | i_xori | i_lui;
  assign i_shift   = i_sll | i_srl | i_sra;
  assign legal     = i_add | i_sub | i_and | i_or | i_xor | i_shift | i_jr |
                     i_imm_alu | i_lw | i_sw | i_beq | i_bne | i_j | i_jal;

  // Legacy memory is always ready; a timeout can only follow a not-ready cycle.
  assign rdy      = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign wait_hit = ~rdy & (cnt_q == CNT_LAST);

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign mem_timeout = timeout_q;
  assign fault       = (state_q == S_FAULT);

  // ALU operation selected by the decoded instruction
  always_comb begin
    if (i_sub)                                alu_code = 4'b0100;
    else if (i_and | i_andi)                  alu_code = 4'b0001;
    else if (i_or | i_ori)                    alu_code = 4'b0101;
    else if (i_xor | i_xori | i_beq | i_bne)  alu_code = 4'b0010;
    else if (i_lui)                           alu_code = 4'b0110;
    else if (i_sll)                           alu_code = 4'b0011;
    else if (i_srl)                           alu_code = 4'b0111;
    else if (i_sra)                           alu_code = 4'b1111;
    else                                      alu_code = 4'b0000;
  end

  // State, wait counter and sticky fault flags
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IF;
      cnt_q     <= CNT_ZERO;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state, wait counting and fault flag setting
  always_comb begin
    state_d   = S_IF;
    cnt_d     = CNT_ZERO;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IF: begin
        if (rdy) begin
          state_d = S_ID;
        end else if (wait_hit) begin
          state_d   = S_FAULT;
          timeout_d = 1'b1;
        end else begin
          state_d = S_IF;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_ID: begin
        if (i_j | i_jal | i_jr) begin
          state_d = S_IF;
        end else if (!legal) begin
          state_d   = S_FAULT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (i_beq | i_bne)    state_d = S_IF;
        else if (i_lw | i_sw) state_d = S_MEM;
        else                  state_d = S_WB;
      end
      S_MEM: begin
        if (rdy) begin
          state_d = i_lw ? S_WB : S_IF;
        end else if (wait_hit) begin
          state_d   = S_FAULT;
          timeout_d = 1'b1;
        end else begin
          state_d = S_MEM;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_WB:    state_d = S_IF;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IF;
    endcase
  end

  // Datapath strobes and selects for the current state
  always_comb begin
    mem_req  = 1'b0;
    wpc      = 1'b0;
    wir      = 1'b0;
    wmem     = 1'b0;
    wreg     = 1'b0;
    iord     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    aluc     = 4'b0000;
    shift    = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'd0;
    pcsource = 2'd0;
    jal      = 1'b0;
    sext     = 1'b1;
    case (state_q)
      S_IF: begin
        alusrca = 1'b1;
        alusrcb = 2'd1;
        if (rdy) begin
          mem_req = 1'b1;
          wpc     = 1'b1;
          wir     = 1'b1;
        end else if (wait_hit) begin
          mem_req = 1'b0;  // access abandoned on timeout
        end else begin
          mem_req = 1'b1;
        end
      end
      S_ID: begin
        if (i_j | i_jal) begin
          pcsource = 2'd3;
          wpc      = 1'b1;
          jal      = i_jal;
          wreg     = i_jal;
        end else if (i_jr) begin
          pcsource = 2'd2;
          wpc      = 1'b1;
        end else if (legal) begin
          alusrca = 1'b1;      // branch target precompute
          alusrcb = 2'd3;
        end else begin
          wpc = 1'b0;          // trapped: nothing written
        end
      end
      S_EXE: begin
        aluc = alu_code;
        if (i_beq | i_bne) begin
          pcsource = 2'd1;
          wpc      = (i_beq & z) | (i_bne & ~z);
        end else if (i_lw | i_sw) begin
          alusrcb = 2'd2;
        end else begin
          shift   = i_shift;
          alusrcb = i_imm_alu ? 2'd2 : 2'd0;
          sext    = ~(i_andi | i_ori | i_xori);
        end
      end
      S_MEM: begin
        iord = 1'b1;
        if (wait_hit) begin
          mem_req = 1'b0;
          wmem    = 1'b0;
        end else begin
          mem_req = 1'b1;
          wmem    = i_sw;
        end
      end
      S_WB: begin
        wreg  = 1'b1;
        regrt = i_lw | i_imm_alu;
        m2reg = i_lw;
      end
      S_FAULT: mem_req = 1'b0;
      default: mem_req = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mccu_wait.sv
// Scoreboard bench for mccu_wait: dut index 0 waits on memory, index 1 is legacy.
module tb_mccu_wait;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetn;
  logic [5:0] op, func;
  logic       z, mem_ready;

  logic [1:0] mem_req_s, wpc_s, wir_s, wmem_s, wreg_s, iord_s, regrt_s, m2reg_s;
  logic [1:0] shift_s, alusrca_s, jal_s, sext_s, illegal_s, mem_timeout_s, fault_s;
  logic [3:0] aluc_s [2];
  logic [1:0] alusrcb_s [2];
  logic [1:0] pcsource_s [2];
  logic [2:0] state_s [2];

  mccu_wait #(.MEM_WAIT_EN(1'b1), .TO_W(4), .TIMEOUT(15)) dut_wait (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
    .mem_req(mem_req_s[0]), .wpc(wpc_s[0]), .wir(wir_s[0]), .wmem(wmem_s[0]),
    .wreg(wreg_s[0]), .iord(iord_s[0]), .regrt(regrt_s[0]), .m2reg(m2reg_s[0]),
    .aluc(aluc_s[0]), .shift(shift_s[0]), .alusrca(alusrca_s[0]), .alusrcb(alusrcb_s[0]),
    .pcsource(pcsource_s[0]), .jal(jal_s[0]), .sext(sext_s[0]), .state(state_s[0]),
    .illegal(illegal_s[0]), .mem_timeout(mem_timeout_s[0]), .fault(fault_s[0]));

  mccu_wait #(.MEM_WAIT_EN(1'b0), .TO_W(4), .TIMEOUT(15)) dut_legacy (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
    .mem_req(mem_req_s[1]), .wpc(wpc_s[1]), .wir(wir_s[1]), .wmem(wmem_s[1]),
    .wreg(wreg_s[1]), .iord(iord_s[1]), .regrt(regrt_s[1]), .m2reg(m2reg_s[1]),
    .aluc(aluc_s[1]), .shift(shift_s[1]), .alusrca(alusrca_s[1]), .alusrcb(alusrcb_s[1]),
    .pcsource(pcsource_s[1]), .jal(jal_s[1]), .sext(sext_s[1]), .state(state_s[1]),
    .illegal(illegal_s[1]), .mem_timeout(mem_timeout_s[1]), .fault(fault_s[1]));

  // Expected vector layout:
  // {state[3], strb{mem_req,wpc,wir,wmem,wreg,iord,jal}[7], aluc[4], alusrcb[2],
  //  pcsource[2], misc{alusrca,shift,regrt,m2reg,sext}[5], flags{illegal,mem_timeout,fault}[3]}
  typedef struct {
    string       name;
    int          sel;
    logic [25:0] v;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  function automatic logic [25:0] observed(input int i);
    return {state_s[i], mem_req_s[i], wpc_s[i], wir_s[i], wmem_s[i], wreg_s[i], iord_s[i],
            jal_s[i], aluc_s[i], alusrcb_s[i], pcsource_s[i], alusrca_s[i], shift_s[i],
            regrt_s[i], m2reg_s[i], sext_s[i], illegal_s[i], mem_timeout_s[i], fault_s[i]};
  endfunction

  // Monitor: check every expectation queued for the current cycle
  initial begin
    forever begin
      @(negedge clock);
      while (sb.size() > 0) begin
        exp_t e;
        logic [25:0] act;
        e   = sb.pop_front();
        act = observed(e.sel);
        total++;
        if (act === e.v) passed++;
        else $display("FAIL %s (dut %0d): got %h required %h", e.name, e.sel, act, e.v);
      end
    end
  end

  task automatic ex(input string name, input int sel, input logic [2:0] st,
                    input logic [6:0] strb, input logic [3:0] alu, input logic [1:0] srcb,
                    input logic [1:0] pcs, input logic [4:0] misc, input logic [2:0] flg);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.v    = {st, strb, alu, srcb, pcs, misc, flg};
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic [5:0] o, input logic [5:0] f, input logic zz,
                        input logic r);
    op = o; func = f; z = zz; mem_ready = r;
  endtask

  // Common per-cycle expectations
  task automatic if_wait(input string n, input int s);
    ex(n, s, 3'd0, 7'b1000000, 4'b0000, 2'd1, 2'd0, 5'b10001, 3'b000);
  endtask
  task automatic if_rdy(input string n, input int s);
    ex(n, s, 3'd0, 7'b1110000, 4'b0000, 2'd1, 2'd0, 5'b10001, 3'b000);
  endtask
  task automatic id_go(input string n, input int s);
    ex(n, s, 3'd1, 7'b0000000, 4'b0000, 2'd3, 2'd0, 5'b10001, 3'b000);
  endtask

  // Asynchronous reset in the middle of a cycle, checked while held
  task automatic do_reset();
    mem_ready = 1'b0;
    resetn    = 1'b0;
    #1;
    if_wait("reset_sif", 0);
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    set_in(6'b000000, 6'b100000, 1'b0, 1'b0);
    #1;
    if_wait("por_main", 0);
    if_rdy("por_legacy", 1);
    tick();
    resetn = 1'b1;

    // Legacy add: 0,1,2,4,0 regardless of mem_ready
    if_rdy("leg_add_if", 1); tick();
    id_go("leg_add_id", 1); tick();
    ex("leg_add_exe", 1, 3'd2, 7'b0000000, 4'b0000, 2'd0, 2'd0, 5'b00001, 3'b000); tick();
    ex("leg_add_wb", 1, 3'd4, 7'b0000100, 4'b0000, 2'd0, 2'd0, 5'b00001, 3'b000); tick();
    if_rdy("leg_add_back", 1);
    // Legacy sw: SMEM lasts one cycle even with mem_ready low
    set_in(6'b101011, 6'b000000, 1'b0, 1'b0); tick();
    id_go("leg_sw_id", 1); tick();
    ex("leg_sw_exe", 1, 3'd2, 7'b0000000, 4'b0000, 2'd2, 2'd0, 5'b00001, 3'b000); tick();
    ex("leg_sw_mem", 1, 3'd3, 7'b1001010, 4'b0000, 2'd0, 2'd0, 5'b00001, 3'b000); tick();
    if_rdy("leg_sw_back", 1);
    tick();

    // Fetch wait then store wait
    do_reset();
    set_in(6'b101011, 6'b000000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin if_wait("fetch_wait", 0); tick(); end
    mem_ready = 1'b1; if_rdy("fetch_done", 0); tick();
    id_go("sw_id", 0); tick();
    ex("sw_exe", 0, 3'd2, 7'b0000000, 4'b0000, 2'd2, 2'd0, 5'b00001, 3'b000); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ex("sw_mem_wait", 0, 3'd3, 7'b1001010, 4'b0000, 2'd0, 2'd0, 5'b00001, 3'b000); tick();
    end
    mem_ready = 1'b1;
    ex("sw_mem_done", 0, 3'd3, 7'b1001010, 4'b0000, 2'd0, 2'd0, 5'b00001, 3'b000); tick();

    // lw with 10-cycle waits in both phases: counter must clear between phases
    set_in(6'b100011, 6'b000000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin if_wait("lw_fetch_wait", 0); tick(); end
    mem_ready = 1'b1; if_rdy("lw_fetch_done", 0); tick();
    id_go("lw_id", 0); tick();
    ex("lw_exe", 0, 3'd2, 7'b0000000, 4'b0000, 2'd2, 2'd0, 5'b00001, 3'b000); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ex("lw_mem_wait", 0, 3'd3, 7'b1000010, 4'b0000, 2'd0, 2'd0, 5'b00001, 3'b000); tick();
    end
    mem_ready = 1'b1;
    ex("lw_mem_done", 0, 3'd3, 7'b1000010, 4'b0000, 2'd0, 2'd0, 5'b00001, 3'b000); tick();
    ex("lw_wb", 0, 3'd4, 7'b0000100, 4'b0000, 2'd0, 2'd0, 5'b00111, 3'b000); tick();

    // beq taken, bne not taken (z = 1 for both)
    set_in(6'b000100, 6'b000000, 1'b1, 1'b1);
    if_rdy("beq_if", 0); tick();
    id_go("beq_id", 0); tick();
    ex("beq_exe", 0, 3'd2, 7'b0100000, 4'b0010, 2'd0, 2'd1, 5'b00001, 3'b000); tick();
    set_in(6'b000101, 6'b000000, 1'b1, 1'b1);
    if_rdy("bne_if", 0); tick();
    id_go("bne_id", 0); tick();
    ex("bne_exe", 0, 3'd2, 7'b0000000, 4'b0010, 2'd0, 2'd1, 5'b00001, 3'b000); tick();

    // andi: zero-extended immediate, rt destination
    set_in(6'b001100, 6'b000000, 1'b0, 1'b1);
    if_rdy("andi_if", 0); tick();
    id_go("andi_id", 0); tick();
    ex("andi_exe", 0, 3'd2, 7'b0000000, 4'b0001, 2'd2, 2'd0, 5'b00000, 3'b000); tick();
    ex("andi_wb", 0, 3'd4, 7'b0000100, 4'b0000, 2'd0, 2'd0, 5'b00101, 3'b000); tick();

    // sra: shamt on ALU A
    set_in(6'b000000, 6'b000011, 1'b0, 1'b1);
    if_rdy("sra_if", 0); tick();
    id_go("sra_id", 0); tick();
    ex("sra_exe", 0, 3'd2, 7'b0000000, 4'b1111, 2'd0, 2'd0, 5'b01001, 3'b000); tick();
    ex("sra_wb", 0, 3'd4, 7'b0000100, 4'b0000, 2'd0, 2'd0, 5'b00001, 3'b000); tick();

    // jal and jr complete in SID
    set_in(6'b000011, 6'b000000, 1'b0, 1'b1);
    if_rdy("jal_if", 0); tick();
    ex("jal_id", 0, 3'd1, 7'b0100101, 4'b0000, 2'd0, 2'd3, 5'b00001, 3'b000); tick();
    set_in(6'b000000, 6'b001000, 1'b0, 1'b1);
    if_rdy("jr_if", 0); tick();
    ex("jr_id", 0, 3'd1, 7'b0100000, 4'b0000, 2'd0, 2'd2, 5'b00001, 3'b000); tick();

    // Illegal opcode traps and stays in SFAULT
    set_in(6'b111111, 6'b000000, 1'b0, 1'b1);
    if_rdy("ill_if", 0); tick();
    ex("ill_id", 0, 3'd1, 7'b0000000, 4'b0000, 2'd0, 2'd0, 5'b00001, 3'b000); tick();
    for (int i = 0; i < 10; i++) begin
      z = i[0];
      ex("ill_fault", 0, 3'd5, 7'b0000000, 4'b0000, 2'd0, 2'd0, 5'b00001, 3'b101); tick();
    end

    // Fetch timeout: 14 waits, 15th forces strobes off, then SFAULT
    do_reset();
    set_in(6'b000000, 6'b100000, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin if_wait("to_fetch_wait", 0); tick(); end
    ex("to_fetch_hit", 0, 3'd0, 7'b0000000, 4'b0000, 2'd1, 2'd0, 5'b10001, 3'b000); tick();
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ex("to_fault", 0, 3'd5, 7'b0000000, 4'b0000, 2'd0, 2'd0, 5'b00001, 3'b011); tick();
    end

    // Store timeout: wmem dropped in the timeout cycle
    do_reset();
    set_in(6'b101011, 6'b000000, 1'b0, 1'b1);
    if_rdy("tos_if", 0); tick();
    id_go("tos_id", 0); tick();
    ex("tos_exe", 0, 3'd2, 7'b0000000, 4'b0000, 2'd2, 2'd0, 5'b00001, 3'b000); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      ex("tos_mem_wait", 0, 3'd3, 7'b1001010, 4'b0000, 2'd0, 2'd0, 5'b00001, 3'b000); tick();
    end
    ex("tos_mem_hit", 0, 3'd3, 7'b0000010, 4'b0000, 2'd0, 2'd0, 5'b00001, 3'b000); tick();
    ex("tos_fault", 0, 3'd5, 7'b0000000, 4'b0000, 2'd0, 2'd0, 5'b00001, 3'b011); tick();
    do_reset();

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clock);
    @(negedge clock);
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mccu_wait.md
Name: mccu_wait

Overview:
Multicycle MIPS control unit with a memory wait-state handshake, a bounded-wait timeout and illegal-instruction trapping.
- Drives the same datapath controls as the existing multicycle controller: PC/IR write, memory write, register write, ALU mux selects and ALU op.
- Every memory phase (fetch, lw, sw) waits for mem_ready instead of completing in a fixed single cycle.
- Sits between the instruction register decode fields and the multicycle datapath and memory interface.

Parameters:
MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1 (legacy single-cycle memory)
TO_W, 4, width of the wait-cycle counter
TIMEOUT, 15, consecutive not-ready cycles in one memory phase that trigger a fault; must be ≤ 2^TO_W-1 and ≥ 1

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
op  in  6  instruction opcode (from IR)
func  in  6  R-type function field
z  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access requested (SIF, SMEM)
wpc  out  1  PC write enable
wir  out  1  IR write enable
wmem  out  1  memory write
wreg  out  1  register file write
iord  out  1  memory address select: 1 = ALU result
regrt  out  1  destination = rt
m2reg  out  1  writeback from memory
aluc  out  4  ALU op
shift  out  1  ALU A = shamt
alusrca  out  1  ALU A = PC
alusrcb  out  2  ALU B: 0 = reg, 1 = 4, 2 = imm, 3 = branch offset
pcsource  out  2  0 = ALU, 1 = branch target reg, 2 = rs (jr), 3 = jump
jal  out  1  write PC+4 to r31
sext  out  1  immediate sign-extend
state  out  3  current state
illegal  out  1  sticky: unsupported instruction decoded
mem_timeout  out  1  sticky: memory wait exceeded TIMEOUT
fault  out  1  state == SFAULT

Behaviour:
- States:
  - SIF = 0, SID = 1, SEXE = 2, SMEM = 3, SWB = 4, SFAULT = 5.
  - Codes 6 and 7 go to SIF on the next clock with no strobes asserted.
- Registered outputs: only state, the wait counter, illegal and mem_timeout are registered. All other outputs are combinational from state, the decode fields, z and mem_ready.
- Output defaults: all strobes 0, aluc = 0000, alusrcb = 0, pcsource = 0, sext = 1. Only the assignments listed below deviate from these.
- Reset (resetn = 0, asynchronous, any state including mid-wait):
  - state = SIF, counter = 0, illegal = 0, mem_timeout = 0.
  - Outputs take their SIF values at once.
- Supported instructions: add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal. Any other op/func is illegal.
- aluc encoding: add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111.
  - addi/lw/sw use 0000; andi 0001; ori 0101; xori 0010.
  - beq/bne use 0010 (xor); z = equal.
- SIF:
  - mem_req = 1, alusrca = 1, alusrcb = 1.
  - If mem_ready: wpc = wir = 1, counter cleared, next SID.
  - Otherwise stay in SIF and count.
- SID:
  - j: pcsource = 3, wpc = 1, next SIF.
  - jal: additionally jal = wreg = 1.
  - jr: pcsource = 2, wpc = 1, next SIF.
  - Illegal: illegal <= 1, next SFAULT, no strobes.
  - Otherwise: alusrca = 1, alusrcb = 3, aluc = 0000 (branch target precompute), next SEXE.
- SEXE:
  - aluc per encoding.
  - beq/bne: pcsource = 1, wpc = beq&z | bne&~z, next SIF.
  - lw/sw: alusrcb = 2, next SMEM.
  - Otherwise:
    - shift = 1 for sll/srl/sra.
    - alusrcb = 2 for addi/andi/ori/xori/lui.
    - sext = 0 for andi/ori/xori.
    - next SWB.
- SMEM:
  - mem_req = iord = 1; wmem = 1 for sw (held for the whole state).
  - On mem_ready: counter cleared; lw next SWB, sw next SIF.
  - Otherwise stay in SMEM and count.
- SWB:
  - wreg = 1.
  - regrt = 1 for lw and all I-type ALU ops.
  - m2reg = 1 for lw.
  - next SIF.
- Wait counter:
  - Increments on each SIF/SMEM cycle with mem_ready = 0; clears on mem_ready or on leaving the phase.
  - When a not-ready cycle occurs with counter == TIMEOUT-1: mem_timeout <= 1, next SFAULT, and that cycle's strobes (wmem included) are forced to 0.
  - mem_ready = 1 in the same cycle wins over timeout.
- SFAULT: all strobes 0, mem_req = 0; stays until reset.
- MEM_WAIT_EN = 0: no waiting, counter held at 0, timeout never fires. Latencies are then:
  - ALU ops 4 cycles
  - lw 5
  - sw 4
  - branches 3
  - jumps 2

Test Plan:
- Legacy timing: MEM_WAIT_EN = 0; add ($1 = $2 + $3) → state 0,1,2,4,0; wreg = 1 only in SWB; aluc = 0000 in SEXE; regrt = 0.
- Fetch wait: mem_ready low 3 cycles then high → SIF held 4 cycles, wpc = wir = 1 only in the 4th; counter returns to 0.
- Store wait: sw with mem_ready low 2 cycles in SMEM → wmem = iord = 1 for 3 cycles, then SIF; wreg never asserted.
- Timeout: TIMEOUT = 15, mem_ready stuck low in SIF → 15th cycle shows all strobes 0, next state 5, mem_timeout = 1 and held; resetn low → state 0, flag 0.
- Illegal: op = 6'b111111 in SID → illegal = 1, state 5, wpc/wreg/wmem stay 0 for 10 cycles.
- Branches: beq with z = 1 → wpc = 1, pcsource = 1 in SEXE; bne with z = 1 → wpc = 0; both return to SIF; andi in SEXE → sext = 0, alusrcb = 2, aluc = 0001.
